// File: rtl/eth_pkg.sv
// Shared Ethernet/IPv4/UDP definitions for the GMII frame generator and the receive-side checker.
package eth_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FILL,
        ST_CSUM,
        ST_PREAMBLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_PAD,
        ST_FCS,
        ST_IFG
    } eth_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
    localparam logic [7:0]  SFD_BYTE        = 8'hD5;
    localparam int          PREAMBLE_LEN    = 8;
    localparam int          HEADER_LEN      = 42;
    localparam logic [15:0] ETHERTYPE_IPV4  = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP    = 8'd17;
    localparam logic [7:0]  IP_TTL          = 8'd64;
    localparam logic [31:0] CRC_POLY        = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT        = 32'hFFFFFFFF;
    localparam int          MIN_UDP_PAYLOAD = 18;
    localparam int          MAX_UDP_WORDS   = 368;

    // Reflected CRC-32, one byte, LSB first; no final inversion here.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    // IPv4 header checksum for the fixed header layout (DF set, TTL 64, UDP).
    function automatic logic [15:0] ip_checksum(input logic [15:0] total_len, input logic [15:0] id,
                                                input logic [31:0] src_ip, input logic [31:0] dst_ip);
        logic [19:0] s;
        s = 20'h04500 + {4'd0, total_len} + {4'd0, id} + 20'h04000
            + {4'd0, IP_TTL, IP_PROTO_UDP}
            + {4'd0, src_ip[31:16]} + {4'd0, src_ip[15:0]}
            + {4'd0, dst_ip[31:16]} + {4'd0, dst_ip[15:0]};
        s = {4'd0, s[15:0]} + {16'd0, s[19:16]};
        s = {4'd0, s[15:0]} + {16'd0, s[19:16]};
        return ~s[15:0];
    endfunction

endpackage

// File: rtl/udp_payload_fifo.sv
// Synchronous payload FIFO with registered read data (block-RAM friendly) and flush.
module udp_payload_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 512
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW:0]       count_reg;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Storage and read port carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
        if (do_pop) begin
            pop_data <= mem[rd_ptr_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/udp_gmii_frame_gen.sv
// Buffers one AXI-Stream payload packet and emits it as a complete Ethernet/IPv4/UDP frame on GMII.
module udp_gmii_frame_gen
    import eth_pkg::*;
#(
    parameter logic [47:0] MAC_SOURCE       = 48'h000000000000,
    parameter logic [47:0] MAC_DESTINATION  = 48'h84A0DAB83142,
    parameter logic [31:0] IP_SOURCE        = {8'd192, 8'd168, 8'd1, 8'd10},
    parameter logic [31:0] IP_DESTINATION   = {8'd192, 8'd168, 8'd1, 8'd120},
    parameter logic [15:0] PORT_SOURCE      = 16'h0000,
    parameter logic [15:0] PORT_DESTINATION = 16'h138D,
    parameter int          IFG_CYCLES       = 12
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [7:0]  gmii_rxd,
    output logic        gmii_rx_dv,
    output logic        gmii_rx_er,
    output logic        frame_done
);
    eth_state_t  state_reg;
    logic [15:0] cnt_reg;
    logic [8:0]  wcnt_reg;
    logic [15:0] id_reg;
    logic [15:0] csum_reg;
    logic [31:0] crc_reg;
    logic [7:0]  rxd_reg;
    logic        dv_reg;
    logic        done_reg;
    logic        tready_reg;

    logic [31:0] fifo_rd_data;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_flush;
    logic        xfer;
    logic [15:0] n_bytes;
    logic [15:0] ip_len;
    logic [15:0] udp_len;
    logic [31:0] crc_fin;
    logic [7:0]  tx_byte;
    logic [335:0] hdr_vec;
    logic [7:0]  hdr_bytes [0:HEADER_LEN-1];

    assign xfer       = s_axis_tvalid & tready_reg;
    // Words past the cap are still handshaken but never stored.
    assign fifo_push  = xfer && (wcnt_reg < 9'(MAX_UDP_WORDS));
    assign fifo_flush = (state_reg == ST_IFG);
    assign n_bytes    = {5'd0, wcnt_reg, 2'b00};
    assign ip_len     = n_bytes + 16'd28;
    assign udp_len    = n_bytes + 16'd8;
    assign crc_fin    = ~crc_reg;

    assign hdr_vec = {MAC_DESTINATION, MAC_SOURCE, ETHERTYPE_IPV4,
                      8'h45, 8'h00, ip_len, id_reg, 16'h4000, IP_TTL, IP_PROTO_UDP,
                      csum_reg, IP_SOURCE, IP_DESTINATION,
                      PORT_SOURCE, PORT_DESTINATION, udp_len, 16'h0000};

    genvar gi;
    generate
        for (gi = 0; gi < HEADER_LEN; gi++) begin : g_hdr
            assign hdr_bytes[gi] = hdr_vec[335 - 8*gi -: 8];
        end
    endgenerate

    // Read one word ahead: the pop issued with a word's last byte lands exactly for the next byte.
    assign fifo_pop = ~fifo_empty &&
                      (((state_reg == ST_HEADER) && (cnt_reg == 16'(HEADER_LEN - 1))) ||
                       ((state_reg == ST_PAYLOAD) && (cnt_reg[1:0] == 2'd3) &&
                        ((cnt_reg + 16'd1) < n_bytes)));

    always_comb begin
        tx_byte = 8'h00;
        case (state_reg)
            ST_CSUM:     tx_byte = PREAMBLE_BYTE;
            ST_PREAMBLE: tx_byte = (cnt_reg == 16'(PREAMBLE_LEN - 1)) ? SFD_BYTE : PREAMBLE_BYTE;
            ST_HEADER:   tx_byte = hdr_bytes[cnt_reg[5:0]];
            ST_PAYLOAD: begin
                case (cnt_reg[1:0])
                    2'd0:    tx_byte = fifo_rd_data[31:24];
                    2'd1:    tx_byte = fifo_rd_data[23:16];
                    2'd2:    tx_byte = fifo_rd_data[15:8];
                    default: tx_byte = fifo_rd_data[7:0];
                endcase
            end
            ST_FCS: begin
                case (cnt_reg[1:0])
                    2'd0:    tx_byte = crc_fin[7:0];
                    2'd1:    tx_byte = crc_fin[15:8];
                    2'd2:    tx_byte = crc_fin[23:16];
                    default: tx_byte = crc_fin[31:24];
                endcase
            end
            default:     tx_byte = 8'h00;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            wcnt_reg   <= '0;
            id_reg     <= '0;
            csum_reg   <= '0;
            crc_reg    <= CRC_INIT;
            rxd_reg    <= 8'h00;
            dv_reg     <= 1'b0;
            done_reg   <= 1'b0;
            tready_reg <= 1'b0;
        end else begin
            rxd_reg  <= 8'h00;
            dv_reg   <= 1'b0;
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_FILL: begin
                    tready_reg <= ~fifo_full;
                    if (fifo_push) begin
                        wcnt_reg <= wcnt_reg + 9'd1;
                    end
                    if (xfer) begin
                        if (s_axis_tlast) begin
                            state_reg  <= ST_CSUM;
                            tready_reg <= 1'b0;
                        end else begin
                            state_reg <= ST_FILL;
                        end
                    end
                end
                ST_CSUM: begin
                    csum_reg  <= ip_checksum(ip_len, id_reg, IP_SOURCE, IP_DESTINATION);
                    crc_reg   <= CRC_INIT;
                    rxd_reg   <= tx_byte;
                    dv_reg    <= 1'b1;
                    cnt_reg   <= 16'd1;
                    state_reg <= ST_PREAMBLE;
                end
                ST_PREAMBLE: begin
                    rxd_reg <= tx_byte;
                    dv_reg  <= 1'b1;
                    if (cnt_reg == 16'(PREAMBLE_LEN - 1)) begin
                        cnt_reg   <= '0;
                        state_reg <= ST_HEADER;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                ST_HEADER: begin
                    rxd_reg <= tx_byte;
                    dv_reg  <= 1'b1;
                    crc_reg <= crc32_byte(crc_reg, tx_byte);
                    if (cnt_reg == 16'(HEADER_LEN - 1)) begin
                        cnt_reg   <= '0;
                        state_reg <= ST_PAYLOAD;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                ST_PAYLOAD: begin
                    rxd_reg <= tx_byte;
                    dv_reg  <= 1'b1;
                    crc_reg <= crc32_byte(crc_reg, tx_byte);
                    if (cnt_reg == n_bytes - 16'd1) begin
                        if (n_bytes < 16'(MIN_UDP_PAYLOAD)) begin
                            cnt_reg   <= cnt_reg + 16'd1;
                            state_reg <= ST_PAD;
                        end else begin
                            cnt_reg   <= '0;
                            state_reg <= ST_FCS;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                ST_PAD: begin
                    rxd_reg <= tx_byte;
                    dv_reg  <= 1'b1;
                    crc_reg <= crc32_byte(crc_reg, tx_byte);
                    if (cnt_reg == 16'(MIN_UDP_PAYLOAD - 1)) begin
                        cnt_reg   <= '0;
                        state_reg <= ST_FCS;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                ST_FCS: begin
                    rxd_reg <= tx_byte;
                    dv_reg  <= 1'b1;
                    if (cnt_reg == 16'd3) begin
                        done_reg  <= 1'b1;
                        id_reg    <= id_reg + 16'd1;
                        wcnt_reg  <= '0;
                        cnt_reg   <= '0;
                        state_reg <= ST_IFG;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                ST_IFG: begin
                    if (int'(cnt_reg) + 1 >= IFG_CYCLES) begin
                        cnt_reg    <= '0;
                        tready_reg <= 1'b1;
                        state_reg  <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    udp_payload_fifo #(
        .DATA_W (32),
        .DEPTH  (512)
    ) u_fifo (
        .clk       (aclk),
        .srst      (areset),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (s_axis_tdata),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign s_axis_tready = tready_reg;
    assign gmii_rxd      = rxd_reg;
    assign gmii_rx_dv    = dv_reg;
    assign gmii_rx_er    = 1'b0;
    assign frame_done    = done_reg;

endmodule
